// File: rtl/descrambler_ctrl.sv
// rtl/descrambler_ctrl.sv - receive-side frame sync tracker and keystream descrambler
// Strips sync words, drives the LFSR selection word and XORs the returned keystream onto payload.
module descrambler_ctrl #(
  parameter logic [15:0] SYNC_WORD = 16'hA5C3,
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned MISS_MAX  = 3,
  parameter logic [63:0] SEED_DEF  = 64'h0123_4567_89AB_CDEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [63:0] seed_in,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [63:0] sel_out,
  input  logic [15:0] key_in,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        locked,
  output logic [7:0]  sync_lost_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [9:0] FRAME_LEN_W = 10'(FRAME_LEN);
  localparam logic [3:0] MISS_MAX_W  = 4'(MISS_MAX);

  state_t      state;
  logic [63:0] seed_reg;
  logic [9:0]  word_cnt;
  logic [3:0]  miss_cnt;

  logic        accept;
  logic        is_sync;
  logic        sync_slot;
  logic [3:0]  miss_inc;
  logic [63:0] sel_step;

  // Output register drains or refills in the same cycle, so a stalled consumer is the only blocker.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_sync   = (in_data == SYNC_WORD);
  assign sync_slot = (word_cnt == FRAME_LEN_W);
  assign miss_inc  = miss_cnt + 4'd1;
  assign sel_step  = {sel_out[62:0], sel_out[63] ^ sel_out[62] ^ sel_out[60] ^ sel_out[59]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      seed_reg      <= SEED_DEF;
      sel_out       <= SEED_DEF;
      out_valid     <= 1'b0;
      out_data      <= 16'd0;
      locked        <= 1'b0;
      sync_lost_cnt <= 8'd0;
      word_cnt      <= 10'd0;
      miss_cnt      <= 4'd0;
    end else begin
      // A reload in this same cycle still sees the previous seed_reg.
      if (seed_load) begin
        seed_reg <= (seed_in == 64'd0) ? SEED_DEF : seed_in;
      end

      if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (state == HUNT) begin
          if (is_sync) begin
            sel_out  <= seed_reg;
            word_cnt <= 10'd0;
            miss_cnt <= 4'd0;
            state    <= LOCK;
            locked   <= 1'b1;
          end
        end else if (!sync_slot) begin
          out_data  <= in_data ^ key_in;
          out_valid <= 1'b1;
          sel_out   <= sel_step;
          word_cnt  <= word_cnt + 10'd1;
        end else begin
          word_cnt <= 10'd0;
          if (is_sync) begin
            sel_out  <= seed_reg;
            miss_cnt <= 4'd0;
          end else begin
            // A missed sync slot keeps the keystream running as though it were payload.
            sel_out  <= sel_step;
            miss_cnt <= miss_inc;
            if (miss_inc == MISS_MAX_W) begin
              state  <= HUNT;
              locked <= 1'b0;
              if (sync_lost_cnt != 8'hFF) begin
                sync_lost_cnt <= sync_lost_cnt + 8'd1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_descrambler_ctrl.sv
// tb/tb_descrambler_ctrl.sv - randomized check of descrambler_ctrl against a frame-level model
module tb_descrambler_ctrl;

  localparam logic [15:0] SYNC     = 16'hA5C3;
  localparam int          FL       = 64;
  localparam int          MISS_MAX = 3;
  localparam logic [63:0] SEED_DEF = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [63:0] seed_in;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [63:0] sel_out;
  logic [15:0] key_in;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        locked;
  logic [7:0]  sync_lost_cnt;

  always #5 clk = ~clk;

  // Stand-in for the keystream mux: any fixed function of the selection word works.
  function automatic logic [15:0] keyf(input logic [63:0] s);
    return s[63:48] ^ s[15:0] ^ {s[31:24], s[39:32]};
  endfunction

  assign key_in = keyf(sel_out);

  descrambler_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seed_load     (seed_load),
    .seed_in       (seed_in),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .sel_out       (sel_out),
    .key_in        (key_in),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .locked        (locked),
    .sync_lost_cnt (sync_lost_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame-level reference model
  bit          m_lock;
  int          m_pos;
  int          m_miss;
  int          m_lost;
  logic [63:0] m_sel;
  logic [63:0] m_seed;
  logic [15:0] exp_q[$];
  bit          reload_seen;

  // Stimulus controls
  int          p_valid = 100;
  int          p_ready = 100;
  int          junk_left = 0;
  int          miss_left = 0;
  bit          zero_payload = 0;
  bit          rand_mode = 0;
  bit          seed_req = 0;
  logic [63:0] seed_val;
  bit          have_word;
  logic [15:0] cur_word;
  int          acc_cnt = 0;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [63:0] fb;
    fb = ((s >> 63) ^ (s >> 62) ^ (s >> 60) ^ (s >> 59)) & 64'd1;
    return (s << 1) | fb;
  endfunction

  task automatic model_reset();
    m_lock = 0;
    m_pos  = 0;
    m_miss = 0;
    m_lost = 0;
    m_sel  = SEED_DEF;
    m_seed = SEED_DEF;
    exp_q.delete();
    have_word = 0;
  endtask

  task automatic model_accept(input logic [15:0] w);
    if (!m_lock) begin
      if (w == SYNC) begin
        m_lock = 1;
        m_pos  = 0;
        m_miss = 0;
        m_sel  = m_seed;
        reload_seen = 1;
      end
    end else if (m_pos < FL) begin
      exp_q.push_back(w ^ keyf(m_sel));
      m_sel = lfsr_next(m_sel);
      m_pos++;
    end else begin
      m_pos = 0;
      if (w == SYNC) begin
        m_sel  = m_seed;
        m_miss = 0;
        reload_seen = 1;
      end else begin
        m_sel = lfsr_next(m_sel);
        m_miss++;
        if (m_miss == MISS_MAX) begin
          m_lock = 0;
          if (m_lost < 255) m_lost++;
        end
      end
    end
  endtask

  function automatic logic [15:0] rand_nonsync();
    logic [15:0] r;
    r = 16'($urandom);
    if (r == SYNC) r = ~r;
    return r;
  endfunction

  function automatic logic [15:0] pick_word();
    if (!m_lock) begin
      if (junk_left > 0) begin
        junk_left--;
        return rand_nonsync();
      end
      if (rand_mode && $urandom_range(0, 2) == 0) return rand_nonsync();
      return SYNC;
    end
    if (m_pos == FL) begin
      if (miss_left > 0) begin
        miss_left--;
        return 16'h0000;
      end
      if (rand_mode && $urandom_range(0, 4) == 0) return rand_nonsync();
      return SYNC;
    end
    return zero_payload ? 16'h0000 : 16'($urandom);
  endfunction

  // Called at posedge+1; checks registered state, drives one cycle, returns at next posedge+1.
  task automatic step_cycle();
    bit exp_ready;
    bit acc;
    check("sel_out", sel_out, m_sel);
    check("locked", 64'(locked), 64'(m_lock));
    check("sync_lost_cnt", 64'(sync_lost_cnt), 64'(m_lost));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q[0]));

    if (!have_word) begin
      cur_word  = pick_word();
      have_word = 1;
    end
    in_data   = cur_word;
    in_valid  = ($urandom_range(1, 100) <= p_valid);
    out_ready = ($urandom_range(1, 100) <= p_ready);
    if (seed_req) begin
      seed_load = 1'b1;
      seed_in   = seed_val;
      seed_req  = 0;
    end else if (rand_mode && $urandom_range(0, 39) == 0) begin
      seed_load = 1'b1;
      seed_in   = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
    end else begin
      seed_load = 1'b0;
      seed_in   = {$urandom, $urandom};
    end
    #1;
    exp_ready = (exp_q.size() == 0) || out_ready;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    acc = in_valid && exp_ready;
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    if (acc) begin
      model_accept(cur_word);
      have_word = 0;
      acc_cnt++;
    end
    if (seed_load) m_seed = (seed_in == 64'd0) ? SEED_DEF : seed_in;
    @(posedge clk);
    #1;
  endtask

  task automatic run_words(input int n);
    int start;
    int cyc;
    start = acc_cnt;
    cyc   = 0;
    while ((acc_cnt - start) < n && cyc < 20 * n + 100) begin
      step_cycle();
      cyc++;
    end
    check("words_done", 64'(acc_cnt - start), 64'(n));
  endtask

  task automatic run_until_reload();
    int cyc;
    reload_seen = 0;
    cyc = 0;
    while (!reload_seen && cyc < 2000) begin
      step_cycle();
      cyc++;
    end
    check("reload_seen", 64'(reload_seen), 64'd1);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b0;
    seed_load = 1'b0;
    seed_in   = 64'd0;
    seed_val  = 64'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_sel_out", sel_out, SEED_DEF);
    check("rst_sync_lost", 64'(sync_lost_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Junk before the first sync, then a zero-payload frame exposing the raw keystream
    p_valid = 100; p_ready = 100; junk_left = 3; zero_payload = 1;
    run_words(3);
    check("hunt_locked", 64'(locked), 64'd0);
    check("hunt_out_valid", 64'(out_valid), 64'd0);
    check("hunt_lost", 64'(sync_lost_cnt), 64'd0);
    run_words(1);
    check("lock_after_sync", 64'(locked), 64'd1);
    check("first_sel", sel_out, 64'h0123_4567_89AB_CDEF);
    run_words(FL);
    zero_payload = 0;

    // Three missed sync slots drop lock
    miss_left = 3; p_valid = 70; p_ready = 60;
    run_words(3 + 2 * FL);
    check("miss_unlocked", 64'(locked), 64'd0);
    check("miss_lost_cnt", 64'(sync_lost_cnt), 64'd1);

    // Relock, then stall the consumer mid-frame
    junk_left = 2; p_valid = 100; p_ready = 100;
    run_words(2 + 1 + 10);
    p_ready = 0;
    repeat (5) begin
      step_cycle();
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    p_ready = 100;
    run_words(FL - 10);

    // Seed loading: zero maps to default, new seed waits for the next reload
    seed_req = 1; seed_val = {$urandom, $urandom} | 64'd1;
    run_words(5);
    seed_req = 1; seed_val = 64'd0;
    run_until_reload();
    check("zero_seed_reload", sel_out, SEED_DEF);
    run_words(20);
    seed_req = 1; seed_val = 64'hFFFF_0000_FFFF_0000;
    run_words(5);
    run_until_reload();
    check("new_seed_reload", sel_out, 64'hFFFF_0000_FFFF_0000);

    // Randomized traffic with misses, junk and seed loads
    rand_mode = 1; p_valid = 75; p_ready = 70;
    run_words(20 * (FL + 1));
    rand_mode = 0;

    // Asynchronous reset while a word is held
    p_valid = 100; p_ready = 100;
    cyc = 0;
    while (!(m_lock && exp_q.size() != 0 && m_pos < FL) && cyc < 1000) begin
      step_cycle();
      cyc++;
    end
    p_ready = 0;
    step_cycle();
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_locked", 64'(locked), 64'd0);
    check("arst_sel_out", sel_out, SEED_DEF);
    check("arst_sync_lost", 64'(sync_lost_cnt), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p_ready = 100;
    run_words(2 + FL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
